// File: rtl/pt_ring_link_arb.sv
// -----------------------------------------------------------------------------
// pt_ring_link_arb
//
// Packet-level round-robin arbiter sharing one ring output link between NREQ
// node FIFOs (local inject and ring-through). A grant is locked for a whole
// packet. Flits reach the link through a single output register with a
// valid/ready handshake. A packet that runs to MAX_FLITS flits without a tail
// is cut off, and a sticky error is raised.
//
// Parameters
//   WIDTH      flit data width
//   NREQ       number of requesters (2..8; 1 degenerates to pass-through)
//   MAX_FLITS  flits per packet before a forced release (>= 2)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous reset, active low
//   iReqVld    per-requester head flit valid (FIFO not empty)
//   iReqDat    per-requester head flit data, requester i in slice i
//   iReqLast   per-requester head flit is a packet tail
//   oReqRdEn   pop strobe back to the requester FIFOs, one-hot or zero
//   oLinkVld   link flit valid
//   oLinkDat   link flit data
//   oLinkLast  link flit is a packet tail
//   iLinkRdy   downstream accepts the link flit when high with oLinkVld
//   oGrant     registered one-hot current owner, zero while idle
//   oBusy      a packet transfer is in progress
//   oErr       sticky over-length packet error
// -----------------------------------------------------------------------------
module pt_ring_link_arb #(
   parameter int WIDTH     = 32,
   parameter int NREQ      = 2,
   parameter int MAX_FLITS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        iReqVld,
   input  logic [NREQ*WIDTH-1:0]  iReqDat,
   input  logic [NREQ-1:0]        iReqLast,
   output logic [NREQ-1:0]        oReqRdEn,
   output logic                   oLinkVld,
   output logic [WIDTH-1:0]       oLinkDat,
   output logic                   oLinkLast,
   input  logic                   iLinkRdy,
   output logic [NREQ-1:0]        oGrant,
   output logic                   oBusy,
   output logic                   oErr
);

   // Index width kept at least one bit so NREQ=1 still elaborates.
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   // The counter only has to reach MAX_FLITS-1: that pop always releases.
   localparam int CNTW = $clog2(MAX_FLITS);

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_FLITS - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);
   localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t            state_q;
   logic [IDXW-1:0]   ptr_q;
   logic [IDXW-1:0]   owner_q;
   logic [CNTW-1:0]   cnt_q;
   logic [NREQ-1:0]   grant_q;
   logic              link_vld_q;
   logic [WIDTH-1:0]  link_dat_q;
   logic              link_last_q;
   logic              err_q;

   logic [IDXW-1:0]   ptr_d;
   logic [CNTW-1:0]   cnt_d;

   logic [WIDTH-1:0]  req_dat [NREQ];

   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;

   logic              owner_vld;
   logic              owner_last;
   logic [WIDTH-1:0]  owner_dat;
   logic              space;
   logic              pop;
   logic              at_limit;
   logic              release_pkt;
   logic              overlen;

   // ------------------------------------------------------------------
   // Unpack the flat data bus into per-requester slices and build the
   // pop strobes. Only the owner can ever see its strobe.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_dat[gi]  = iReqDat[gi*WIDTH +: WIDTH];
         assign oReqRdEn[gi] = pop & (owner_q == IDXW'(gi));
      end
   endgenerate

   // (base + k) mod NREQ, with k < NREQ so one conditional subtract suffices.
   function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) begin
         s = s - NREQ;
      end
      return IDXW'(s);
   endfunction

   // ------------------------------------------------------------------
   // Round-robin pick: first valid requester at or after ptr, wrapping.
   // Only consulted in IDLE, so non-owners are ignored during a packet.
   // ------------------------------------------------------------------
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_found && iReqVld[wrap_add(ptr_q, k)]) begin
            pick_found = 1'b1;
            pick_idx   = wrap_add(ptr_q, k);
         end
      end
   end

   // ------------------------------------------------------------------
   // Owner datapath and handshake.
   // The output register has room when empty or being drained this cycle,
   // so a pop and a downstream accept can overlap without a bubble.
   // ------------------------------------------------------------------
   assign owner_vld   = iReqVld[owner_q];
   assign owner_last  = iReqLast[owner_q];
   assign owner_dat   = req_dat[owner_q];
   assign space       = ~link_vld_q | iLinkRdy;
   assign pop         = (state_q == ST_XFER) & owner_vld & space;
   assign at_limit    = (cnt_q == CNT_LAST);
   assign release_pkt = pop & (owner_last | at_limit);
   // A forced cut: the following flit from this owner starts a new packet.
   assign overlen     = pop & ~owner_last & at_limit;

   // Pointer moves just past the releasing owner.
   assign ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
   assign cnt_d = cnt_q + 1'b1;

   // ------------------------------------------------------------------
   // FSM, output register and sticky error.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         link_vld_q  <= 1'b0;
         link_dat_q  <= '0;
         link_last_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // Output register: load on pop, clear when drained with no refill,
         // otherwise hold (backpressure or an empty cycle with nothing sent).
         if (pop) begin
            link_vld_q  <= 1'b1;
            link_dat_q  <= owner_dat;
            link_last_q <= owner_last;
         end else if (iLinkRdy) begin
            link_vld_q  <= 1'b0;
         end

         if (overlen) begin
            err_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               // The grant cycle never pops; popping starts next cycle.
               if (pick_found) begin
                  state_q <= ST_XFER;
                  owner_q <= pick_idx;
                  grant_q <= GRANT_ONE << pick_idx;
                  cnt_q   <= '0;
               end
            end
            ST_XFER: begin
               // An owner bubble simply waits here; there is no timeout.
               if (pop) begin
                  if (release_pkt) begin
                     state_q <= ST_IDLE;
                     grant_q <= '0;
                     ptr_q   <= ptr_d;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign oGrant    = grant_q;
   assign oBusy     = (state_q == ST_XFER);
   assign oErr      = err_q;
   assign oLinkVld  = link_vld_q;
   assign oLinkDat  = link_dat_q;
   assign oLinkLast = link_last_q;

endmodule
